// File: rtl/swipt_frame_tx.sv
// rtl/swipt_frame_tx.sv - SWIPT serial frame transmitter
// Sends {start, sync 010, mode, type, data[19:0], ones-count csum[7:0]} MSB-first.
// Each bit lasts BIT_PERIOD clocks. A forced-low guard gap follows the frame.
// Optional macro SWIPT_TX_REPEAT_EN: the captured frame is sent a second time.
module swipt_frame_tx #(
  parameter int BIT_PERIOD    = 200000,
  parameter int GUARD_PERIODS = 2,
  parameter int CNT_W         = 20
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swipt_alive_i,
  input  logic [1:0]  program_i,
  input  logic        tx_start_i,
  input  logic [1:0]  mode_i,
  input  logic [1:0]  type_i,
  input  logic [19:0] tx_data_i,
  output logic        tx_ready_o,
  output logic        tx_busy_o,
  output logic        dout_o,
  output logic        tx_done_o,
  output logic        tx_abort_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GUARD} state_t;

  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] PER_ONE    = CNT_W'(1);
  localparam logic [5:0]       GUARD_BITS = 6'(GUARD_PERIODS);
`ifdef SWIPT_TX_REPEAT_EN
  // The repeat copy drives its first bit on the guard's final edge, so that
  // bit needs one count less to stay BIT_PERIOD cycles wide.
  localparam logic [CNT_W-1:0] PER_REP    = CNT_W'(BIT_PERIOD - 2);
`endif

  state_t           state_q;
  logic [27:0]      hdr_q;    // start, sync, mode, type, data as captured on accept
  logic [35:0]      sh_q;     // outgoing frame, MSB is the current bit
  logic [CNT_W-1:0] per_q;    // clocks left in the current bit period
  logic [5:0]       bcnt_q;   // bits left in the frame, or guard periods left
  logic             tx_ready_q;
  logic             tx_busy_q;
  logic             dout_q;
  logic             tx_done_q;
  logic             tx_abort_q;
`ifdef SWIPT_TX_REPEAT_EN
  logic             rep_q;    // second copy in flight
`endif

  logic       link_ok;
  logic [7:0] csum;

  assign link_ok = swipt_alive_i && (program_i == 2'b11);

  // Ones count over the 28 header/data bits of the captured frame.
  always_comb begin
    csum = 8'd0;
    for (int i = 0; i < 28; i++) begin
      csum = csum + {7'd0, hdr_q[i]};
    end
  end

  // Transmit FSM: accept, load, shift out, guard gap, with link-drop abort.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      hdr_q      <= '0;
      sh_q       <= '0;
      per_q      <= '0;
      bcnt_q     <= '0;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      dout_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
`ifdef SWIPT_TX_REPEAT_EN
      rep_q      <= 1'b0;
`endif
    end else begin
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
      if (state_q != S_IDLE && !link_ok) begin
        state_q    <= S_IDLE;
        dout_q     <= 1'b0;
        tx_abort_q <= 1'b1;
        tx_busy_q  <= 1'b0;
        tx_ready_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            dout_q <= 1'b0;
            if (tx_start_i && link_ok && tx_ready_q) begin
              hdr_q      <= {4'b1010, mode_i, type_i, tx_data_i};
              state_q    <= S_LOAD;
              tx_busy_q  <= 1'b1;
              tx_ready_q <= 1'b0;
            end else begin
              tx_ready_q <= link_ok;
            end
          end
          S_LOAD: begin
            sh_q    <= {hdr_q, csum};
            per_q   <= PER_LAST;
            bcnt_q  <= 6'd35;
            state_q <= S_SEND;
`ifdef SWIPT_TX_REPEAT_EN
            rep_q   <= 1'b0;
`endif
          end
          S_SEND: begin
            dout_q <= sh_q[35];
            if (per_q == '0) begin
              if (bcnt_q == 6'd0) begin
                // per_q stays 0 so the guard spends one extra edge, letting
                // the last data bit's registered output finish first.
                bcnt_q  <= GUARD_BITS;
                state_q <= S_GUARD;
              end else begin
                sh_q   <= {sh_q[34:0], 1'b0};
                per_q  <= PER_LAST;
                bcnt_q <= bcnt_q - 6'd1;
              end
            end else begin
              per_q <= per_q - PER_ONE;
            end
          end
          S_GUARD: begin
            dout_q <= 1'b0;
            if (per_q == '0) begin
              if (bcnt_q == 6'd0) begin
`ifdef SWIPT_TX_REPEAT_EN
                if (!rep_q) begin
                  rep_q   <= 1'b1;
                  sh_q    <= {hdr_q, csum};
                  dout_q  <= hdr_q[27];
                  per_q   <= PER_REP;
                  bcnt_q  <= 6'd35;
                  state_q <= S_SEND;
                end else begin
                  tx_done_q <= 1'b1;
                  tx_busy_q <= 1'b0;
                  state_q   <= S_IDLE;
                end
`else
                tx_done_q <= 1'b1;
                tx_busy_q <= 1'b0;
                state_q   <= S_IDLE;
`endif
              end else begin
                bcnt_q <= bcnt_q - 6'd1;
                per_q  <= PER_LAST;
              end
            end else begin
              per_q <= per_q - PER_ONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign tx_busy_o  = tx_busy_q;
  assign dout_o     = dout_q;
  assign tx_done_o  = tx_done_q;
  assign tx_abort_o = tx_abort_q;

endmodule
